// File: rtl/i2s_dac_transmit.sv
// ---------------------------------------------------------------------------
// i2s_dac_transmit
//
// I2S slave transmitter for the codec DAC. The codec drives BCLK and DACLRCK.
// Both codec clocks are oversampled in the CLK domain, so CLK must run at
// least 4x faster than BCLK. Each L/R pair is snapshotted once per frame,
// at the LRCK fall that starts the left half, so the two channels of a frame
// always belong together.
//
// Parameters
//   DATA_W       bits sent per channel, MSB-justified slice codec_x[31 -: DATA_W] (8..32)
//   SYNC_STAGES  synchroniser depth on AUD_BCLK / AUD_DACLRCK (>= 2)
//
// Ports
//   CLK          system clock
//   RESET_N      active-low reset; asserts asynchronously, releases synchronously
//   codec_left   left sample, used only at the frame snapshot
//   codec_right  right sample, used only at the frame snapshot
//   mute         1 = the snapshot takes zeros instead of the samples
//   AUD_BCLK     codec bit clock (asynchronous to CLK)
//   AUD_DACLRCK  codec word select, 0 = left, 1 = right (asynchronous to CLK)
//   AUD_DACDAT   serial data to the codec, changes after BCLK falls
//   frame_strobe one-CLK pulse when a new L/R pair is snapshotted
//   frame_err    sticky; a channel half ended before DATA_W bits went out
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module i2s_dac_transmit #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] codec_left,
    input  logic [31:0] codec_right,
    input  logic        mute,
    input  logic        AUD_BCLK,
    input  logic        AUD_DACLRCK,
    output logic        AUD_DACDAT,
    output logic        frame_strobe,
    output logic        frame_err
);
    localparam int                CNT_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    // Reset: the external reset clears everything at once, but the internal
    // reset is released only on a CLK edge.
    logic [1:0] rst_pipe_reg;
    logic       rst_n_sync;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_pipe_reg <= 2'b00;
        end else begin
            rst_pipe_reg <= {rst_pipe_reg[0], 1'b1};
        end
    end

    assign rst_n_sync = rst_pipe_reg[1];

    // Codec clock synchronisers and BCLK fall detection
    logic [SYNC_STAGES-1:0] bclk_sync_reg;
    logic [SYNC_STAGES-1:0] lrck_sync_reg;
    logic                   bclk_prev_reg;
    logic                   bclk_s;
    logic                   lrck_s;
    logic                   bclk_fall;

    always_ff @(posedge CLK or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            bclk_sync_reg <= '0;
            lrck_sync_reg <= '0;
            bclk_prev_reg <= 1'b0;
        end else begin
            bclk_sync_reg <= {bclk_sync_reg[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync_reg <= {lrck_sync_reg[SYNC_STAGES-2:0], AUD_DACLRCK};
            bclk_prev_reg <= bclk_s;
        end
    end

    assign bclk_s    = bclk_sync_reg[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync_reg[SYNC_STAGES-1];
    assign bclk_fall = bclk_prev_reg & ~bclk_s;

    // Frame snapshot candidates
    logic [DATA_W-1:0] snap_l;
    logic [DATA_W-1:0] snap_r;

    assign snap_l = mute ? '0 : codec_left[31 -: DATA_W];
    assign snap_r = mute ? '0 : codec_right[31 -: DATA_W];

    // The low sample bits below the transmitted slice are intentionally dropped.
    if (DATA_W < 32) begin : g_unused_lsbs
        logic unused_lsbs;
        assign unused_lsbs = ^{codec_left[31-DATA_W:0], codec_right[31-DATA_W:0]};
    end

    // Serialiser FSM
    state_t            state_reg;
    logic              lrck_prev_reg;   // lrck seen at the previous BCLK fall
    logic [DATA_W-1:0] hold_l_reg;
    logic [DATA_W-1:0] hold_r_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic              lrck_edge;

    assign lrck_edge = (lrck_s != lrck_prev_reg);

    always_ff @(posedge CLK or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_reg     <= ST_IDLE;
            lrck_prev_reg <= 1'b0;
            hold_l_reg    <= '0;
            hold_r_reg    <= '0;
            shreg_reg     <= '0;
            bit_cnt_reg   <= '0;
            AUD_DACDAT    <= 1'b0;
            frame_strobe  <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            if (bclk_fall) begin
                lrck_prev_reg <= lrck_s;
                if (lrck_edge) begin
                    // A word that has not fully gone out when its half ends is abandoned.
                    if (state_reg != ST_IDLE && bit_cnt_reg < CNT_FULL) begin
                        frame_err <= 1'b1;
                    end
                    if (!lrck_s) begin
                        // Left half starts a new frame: snapshot both channels
                        // and load the fresh left value directly.
                        hold_l_reg   <= snap_l;
                        hold_r_reg   <= snap_r;
                        shreg_reg    <= snap_l;
                        bit_cnt_reg  <= '0;
                        state_reg    <= ST_LEFT;
                        frame_strobe <= 1'b1;
                    end else if (state_reg != ST_IDLE) begin
                        shreg_reg   <= hold_r_reg;
                        bit_cnt_reg <= '0;
                        state_reg   <= ST_RIGHT;
                    end
                end else if (state_reg != ST_IDLE) begin
                    // The load happens on the LRCK edge fall, so the MSB goes
                    // out one BCLK later: the I2S one-bit delay.
                    if (bit_cnt_reg < CNT_FULL) begin
                        AUD_DACDAT  <= shreg_reg[DATA_W-1];
                        shreg_reg   <= {shreg_reg[DATA_W-2:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
                    end else begin
                        AUD_DACDAT <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
